// File: rtl/coffee_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : coffee_pkg
//  Description : Shared types and constants for the coffee-machine controller
//                (credit width, price, coin-accumulator state encoding).
//  Revision    : 1.0 - initial release
// ============================================================================
package coffee_pkg;

  // Width of the credit bus between the accumulator and the comparator
  localparam int CREDIT_W = 3;

  // Price of one cup, shared with the price comparator
  localparam logic [2:0] PRICE = 3'd3;

  // Coin-accumulator control states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    LOCKED  = 2'd2
  } acc_state_t;

endpackage
`default_nettype wire

// File: rtl/edge_detect.sv
`default_nettype none
// ============================================================================
//  Module      : edge_detect
//  Description : 1-bit rising-edge detector. The history flop clears to 0 on
//                reset, so a level already high at reset release reports one
//                edge on the first active cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic hist;

  // Previous-cycle copy of the input level
  always_ff @(posedge clk) begin
    if (!rst_n) hist <= 1'b0;
    else        hist <= din;
  end

  assign rise = din & ~hist;

endmodule
`default_nettype wire

// File: rtl/coin_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : coin_accumulator
//  Description : Edge-detects coin and cancel inputs, accumulates a saturating
//                credit total for the price comparator, locks the coin gate
//                once credit is sufficient, clears on vend and refunds on
//                cancel.
//  Revision    : 1.0 - initial release
// ============================================================================
module coin_accumulator
  import coffee_pkg::*;
#(
  parameter int WIDTH      = CREDIT_W,
  parameter int COIN_A_VAL = 1,
  parameter int COIN_B_VAL = 2,
  parameter int MAX_CREDIT = 7
) (
  input  logic             Coin_Acc_Clk,
  input  logic             Coin_Acc_Rst_n,
  input  logic             Coin_Acc_Coin_A,
  input  logic             Coin_Acc_Coin_B,
  input  logic             Coin_Acc_Cancel,
  input  logic             Coin_Acc_Enough,
  input  logic             Coin_Acc_Vend_Done,
  output logic [WIDTH-1:0] Coin_Acc_Total,
  output logic             Coin_Acc_Accept,
  output logic             Coin_Acc_Reject,
  output logic             Coin_Acc_Refund_Valid,
  output logic [WIDTH-1:0] Coin_Acc_Refund_Amt
);

  // Two guard bits so total + both coins can never wrap before clamping
  localparam int SUM_W = WIDTH + 2;

  logic             a_edge;
  logic             b_edge;
  logic             cancel_edge;
  logic             coin_edge;
  logic [SUM_W-1:0] add_val;
  logic [SUM_W-1:0] sum_raw;
  logic [WIDTH-1:0] sum_clamped;
  logic             clipped;
  acc_state_t       state;

  edge_detect u_edge_a (
    .clk   (Coin_Acc_Clk),
    .rst_n (Coin_Acc_Rst_n),
    .din   (Coin_Acc_Coin_A),
    .rise  (a_edge)
  );

  edge_detect u_edge_b (
    .clk   (Coin_Acc_Clk),
    .rst_n (Coin_Acc_Rst_n),
    .din   (Coin_Acc_Coin_B),
    .rise  (b_edge)
  );

  edge_detect u_edge_cancel (
    .clk   (Coin_Acc_Clk),
    .rst_n (Coin_Acc_Rst_n),
    .din   (Coin_Acc_Cancel),
    .rise  (cancel_edge)
  );

  assign coin_edge = a_edge | b_edge;

  // Candidate credit: current total plus this cycle's coins, clamped at the ceiling
  always_comb begin
    add_val = '0;
    if (a_edge) add_val = add_val + SUM_W'(COIN_A_VAL);
    if (b_edge) add_val = add_val + SUM_W'(COIN_B_VAL);
    sum_raw     = SUM_W'(Coin_Acc_Total) + add_val;
    clipped     = (sum_raw > SUM_W'(MAX_CREDIT));
    sum_clamped = clipped ? WIDTH'(MAX_CREDIT) : sum_raw[WIDTH-1:0];
  end

  // Control FSM with registered credit, gate and refund outputs
  always_ff @(posedge Coin_Acc_Clk) begin
    if (!Coin_Acc_Rst_n) begin
      state                 <= IDLE;
      Coin_Acc_Total        <= '0;
      Coin_Acc_Accept       <= 1'b1;
      Coin_Acc_Reject       <= 1'b0;
      Coin_Acc_Refund_Valid <= 1'b0;
      Coin_Acc_Refund_Amt   <= '0;
    end else begin
      Coin_Acc_Reject       <= 1'b0;
      Coin_Acc_Refund_Valid <= 1'b0;
      Coin_Acc_Refund_Amt   <= '0;
      case (state)
        IDLE: begin
          // Cancel with no credit has nothing to return
          if (coin_edge) begin
            Coin_Acc_Total  <= sum_clamped;
            Coin_Acc_Reject <= clipped;
            state           <= COLLECT;
          end
        end
        COLLECT: begin
          Coin_Acc_Total  <= sum_clamped;
          Coin_Acc_Reject <= clipped;
          if (Coin_Acc_Enough) begin
            // Enough credit wins over cancel: the vend is committed
            state           <= LOCKED;
            Coin_Acc_Accept <= 1'b0;
          end else if (cancel_edge) begin
            // Refund includes any coin that arrived with the cancel
            Coin_Acc_Refund_Valid <= 1'b1;
            Coin_Acc_Refund_Amt   <= sum_clamped;
            Coin_Acc_Total        <= '0;
            state                 <= IDLE;
          end
        end
        LOCKED: begin
          Coin_Acc_Reject <= coin_edge;
          if (Coin_Acc_Vend_Done) begin
            Coin_Acc_Total  <= '0;
            Coin_Acc_Accept <= 1'b1;
            state           <= IDLE;
          end
        end
        default: begin
          Coin_Acc_Total  <= '0;
          Coin_Acc_Accept <= 1'b1;
          state           <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_coin_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coin_accumulator
//  Description : Self-checking bench for coin_accumulator. Each step drives
//                one cycle of inputs, queues the hand-derived outputs expected
//                after that edge, then pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_coin_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin_a = 1'b0;
  logic       coin_b = 1'b0;
  logic       cancel = 1'b0;
  logic       enough = 1'b0;
  logic       vend_done = 1'b0;
  logic [2:0] total;
  logic       accept;
  logic       reject;
  logic       refund_valid;
  logic [2:0] refund_amt;

  typedef struct {
    string tag;
    int    total;
    int    accept;
    int    reject;
    int    refund_valid;
    int    refund_amt;
  } exp_t;

  exp_t sb_q[$];
  int   checks_total  = 0;
  int   checks_passed = 0;

  coin_accumulator #(
    .WIDTH      (3),
    .COIN_A_VAL (1),
    .COIN_B_VAL (2),
    .MAX_CREDIT (7)
  ) dut (
    .Coin_Acc_Clk          (clk),
    .Coin_Acc_Rst_n        (rst_n),
    .Coin_Acc_Coin_A       (coin_a),
    .Coin_Acc_Coin_B       (coin_b),
    .Coin_Acc_Cancel       (cancel),
    .Coin_Acc_Enough       (enough),
    .Coin_Acc_Vend_Done    (vend_done),
    .Coin_Acc_Total        (total),
    .Coin_Acc_Accept       (accept),
    .Coin_Acc_Reject       (reject),
    .Coin_Acc_Refund_Valid (refund_valid),
    .Coin_Acc_Refund_Amt   (refund_amt)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input int obs, input int exp);
    checks_total++;
    if (obs == exp) checks_passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Drive one cycle of inputs, queue expectations, compare after the edge
  task automatic step(input string tag, input logic r, input logic a, input logic b,
                      input logic c, input logic en, input logic vd,
                      input int e_total, input int e_acc, input int e_rej,
                      input int e_rv, input int e_ra);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst_n     = r;
    coin_a    = a;
    coin_b    = b;
    cancel    = c;
    enough    = en;
    vend_done = vd;
    e.tag = tag; e.total = e_total; e.accept = e_acc; e.reject = e_rej;
    e.refund_valid = e_rv; e.refund_amt = e_ra;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check_value({got.tag, ".total"},  int'(total),        got.total);
    check_value({got.tag, ".accept"}, int'(accept),       got.accept);
    check_value({got.tag, ".reject"}, int'(reject),       got.reject);
    check_value({got.tag, ".rv"},     int'(refund_valid), got.refund_valid);
    check_value({got.tag, ".ra"},     int'(refund_amt),   got.refund_amt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            tag          rst a  b  c  en vd  tot acc rej rv ra
    step("rst0",        0, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    step("rst1",        0, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    step("rel_a_high",  1, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0);
    step("a_low",       1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0);
    step("b_edge",      1, 0, 1, 0, 0, 0,  3, 1, 0, 0, 0);
    step("lock",        1, 0, 1, 0, 1, 0,  3, 0, 0, 0, 0);
    step("lock_a",      1, 1, 1, 0, 1, 0,  3, 0, 1, 0, 0);
    step("lock_idle",   1, 0, 1, 0, 1, 0,  3, 0, 0, 0, 0);
    step("lock_cancel", 1, 0, 1, 1, 1, 0,  3, 0, 0, 0, 0);
    step("vend",        1, 0, 1, 0, 1, 1,  0, 1, 0, 0, 0);
    step("idle",        1, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    step("idle_cancel", 1, 0, 0, 1, 0, 0,  0, 1, 0, 0, 0);
    step("ab_same",     1, 1, 1, 0, 0, 0,  3, 1, 0, 0, 0);
    step("cancel3",     1, 0, 0, 1, 0, 0,  0, 1, 0, 1, 3);
    step("cancel_hold", 1, 0, 0, 1, 0, 0,  0, 1, 0, 0, 0);
    step("b1",          1, 0, 1, 0, 0, 0,  2, 1, 0, 0, 0);
    step("b1_low",      1, 0, 0, 0, 0, 0,  2, 1, 0, 0, 0);
    step("b2",          1, 0, 1, 0, 0, 0,  4, 1, 0, 0, 0);
    step("b2_low",      1, 0, 0, 0, 0, 0,  4, 1, 0, 0, 0);
    step("b3",          1, 0, 1, 0, 0, 0,  6, 1, 0, 0, 0);
    step("b3_low",      1, 0, 0, 0, 0, 0,  6, 1, 0, 0, 0);
    step("b4_clip",     1, 0, 1, 0, 0, 0,  7, 1, 1, 0, 0);
    step("b4_low",      1, 0, 0, 0, 0, 0,  7, 1, 0, 0, 0);
    step("cancel7",     1, 0, 0, 1, 0, 0,  0, 1, 0, 1, 7);
    step("b_to2",       1, 0, 1, 0, 0, 0,  2, 1, 0, 0, 0);
    step("cancel2",     1, 0, 0, 1, 0, 0,  0, 1, 0, 1, 2);
    step("cancel2_hold",1, 0, 0, 1, 0, 0,  0, 1, 0, 0, 0);
    step("b_again",     1, 0, 1, 0, 0, 0,  2, 1, 0, 0, 0);
    step("coin_cancel", 1, 1, 0, 1, 0, 0,  0, 1, 0, 1, 3);
    step("quiet",       1, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    step("b_pre_lock",  1, 0, 1, 0, 0, 0,  2, 1, 0, 0, 0);
    step("a_with_en",   1, 1, 0, 0, 1, 0,  3, 0, 0, 0, 0);
    step("vend2",       1, 0, 0, 0, 1, 1,  0, 1, 0, 0, 0);
    step("idle2",       1, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    step("b_pre_rst",   1, 0, 1, 0, 0, 0,  2, 1, 0, 0, 0);
    step("rst_mid",     0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    step("post_rst",    1, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
`default_nettype wire
